// File: rtl/adc2fifo_packer.sv
// adc2fifo_packer: packs 16-bit ADC samples two-per-word into fixed-length
// frames written to the sample FIFO after an arm/trigger sequence.
//
// Optional feature: define ADC2FIFO_HEADER_EN to prepend a header word
// {16'hA5A5, seq[15:0]} to every frame. The header counts toward FRAME_WORDS.
//
// Ports:
//   sysclk      single clock, rising edge
//   rst         synchronous active-high reset
//   adc_data    16-bit ADC sample
//   adc_valid   adc_data valid this cycle
//   arm         one-cycle capture request (honoured in IDLE only)
//   trigger     capture start (honoured in ARMED only)
//   fifo_full   FIFO full flag, sampled in the write-decision cycle
//   fifo_din    FIFO write data (registered)
//   fifo_wr_en  FIFO write strobe (registered)
//   busy        high while ARMED or CAPTURE (registered)
//   frame_done  one-cycle pulse with the final word slot of a frame
//   overflow    sticky: a word was dropped since reset/arm
module adc2fifo_packer #(
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned SEQ_W       = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  input  logic        arm,
  input  logic        trigger,
  input  logic        fifo_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       low_q, low_d;
  logic              half_q, half_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [31:0]       din_q, din_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic              capture;
  logic              issue;
  logic [31:0]       issue_word;

`ifdef ADC2FIFO_HEADER_EN
  logic [15:0]       seq16;
  assign seq16 = 16'(seq_q);
`endif

  // State and output registers
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      low_q   <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      seq_q   <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, packing and word-issue logic
  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    capture    = 1'b0;
    issue      = 1'b0;
    issue_word = '0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          half_d  = 1'b0;
        end
      end
      S_ARMED: begin
        // The trigger-cycle sample is already part of the frame.
        if (trigger) begin
          state_d = S_CAPTURE;
          capture = 1'b1;
`ifdef ADC2FIFO_HEADER_EN
          // Header is decided here so it lands in the first CAPTURE cycle;
          // no data word can complete in this cycle (half flag is clear).
          issue      = 1'b1;
          issue_word = {16'hA5A5, seq16};
`endif
        end
      end
      S_CAPTURE: begin
        capture = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture && adc_valid) begin
      if (!half_q) begin
        low_d  = adc_data;
        half_d = 1'b1;
      end else begin
        half_d     = 1'b0;
        issue      = 1'b1;
        issue_word = {adc_data, low_q};
      end
    end

    // Dropped words still consume a slot so frame length is fixed in time.
    if (issue) begin
      din_d = issue_word;
      cnt_d = cnt_q + CNT_W'(1);
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
      end
      if (cnt_q == LAST_CNT) begin
        done_d  = 1'b1;
        cnt_d   = '0;
        seq_d   = seq_q + SEQ_W'(1);
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc2fifo_packer.sv
// Scoreboard bench for adc2fifo_packer: stimulus pushes expected FIFO
// writes / frame-end slots; a monitor pops and compares on every output event.
module tb_adc2fifo_packer;

  localparam int unsigned FW    = 16;
  localparam int unsigned SEQ_W = 16;
`ifdef ADC2FIFO_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        sysclk = 1'b0;
  logic        rst;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        arm;
  logic        trigger;
  logic        fifo_full;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  adc2fifo_packer #(.FRAME_WORDS(FW), .SEQ_W(SEQ_W)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .arm        (arm),
    .trigger    (trigger),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic        done;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_seq = '0;
  int          words_issued = 0;
  logic        frame_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: every write or frame-end pulse must match the next expected slot.
  always @(negedge sysclk) begin
    if (fifo_wr_en === 1'b1 || frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output wr_en=%0b din=%h done=%0b", fifo_wr_en, fifo_din, frame_done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_en", 32'(fifo_wr_en), 32'(mon_e.wr));
        if (mon_e.wr) chk("fifo_din", fifo_din, mon_e.data);
        chk("frame_done", 32'(frame_done), 32'(mon_e.done));
        if (mon_e.done) begin
          chk("overflow_at_done", 32'(overflow), 32'(mon_e.ovf));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Reference: the n-th word slot of a frame is written unless the FIFO is
  // full; the FW-th slot ends the frame whether written or dropped.
  task automatic issue_word(input logic full, input logic [31:0] data);
    logic last;
    last = (words_issued == int'(FW) - 1);
    frame_ovf = frame_ovf | full;
    if (!full || last) exp_q.push_back('{wr: !full, data: data, done: last, ovf: frame_ovf});
    words_issued++;
    if (last) exp_seq = exp_seq + 16'd1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_frame(input int gmin, input int gmax, input int full_pct,
                           input int drop_idx, input bit seqd);
    logic [15:0] s_lo;
    int nd;
    nd = int'(FW) - HDR;
    s_lo = '0;
    words_issued = 0;
    frame_ovf = 1'b0;
    // arm cycle; a simultaneous trigger must be ignored
    step();
    arm = 1'b1; trigger = rbit(); adc_valid = 1'b1; adc_data = 16'($urandom); fifo_full = rbit();
    step();
    arm = 1'b0; trigger = 1'b0; adc_valid = rbit(); fifo_full = rbit();
    chk("busy_armed", 32'(busy), 32'd1);
    repeat ($urandom_range(0, 2)) begin
      step();
      arm = rbit(); trigger = 1'b0; adc_valid = rbit(); adc_data = 16'($urandom); fifo_full = rbit();
    end
    for (int k = 0; k < 2 * nd; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(gmin, gmax)) begin
          step();
          arm = rbit(); trigger = rbit(); adc_valid = 1'b0; adc_data = 16'($urandom); fifo_full = rbit();
        end
      end
      step();
      arm       = (k == 0) ? 1'b0 : rbit();
      trigger   = (k == 0) ? 1'b1 : rbit();
      adc_valid = 1'b1;
      adc_data  = seqd ? 16'(k) : 16'($urandom);
      fifo_full = (int'($urandom_range(0, 99)) < full_pct);
      if (k == 0 && HDR == 1) issue_word(fifo_full, {16'hA5A5, exp_seq});
      if (k % 2 == 0) begin
        s_lo = adc_data;
      end else begin
        if (drop_idx == k / 2) fifo_full = 1'b1;
        issue_word(fifo_full, {adc_data, s_lo});
      end
    end
    step();
    arm = 1'b0; trigger = 1'b0; adc_valid = 1'b0; fifo_full = 1'b0;
  endtask

  // Reset after 5 captured samples: completed words remain, rest discarded.
  task automatic run_reset_midframe();
    logic [15:0] s_lo;
    words_issued = 0;
    frame_ovf = 1'b0;
    s_lo = '0;
    step();
    arm = 1'b1; trigger = 1'b0; adc_valid = 1'b0; fifo_full = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      arm = 1'b0; trigger = (k == 0); adc_valid = 1'b1; adc_data = 16'($urandom); fifo_full = 1'b0;
      if (k == 0 && HDR == 1) issue_word(1'b0, {16'hA5A5, exp_seq});
      if (k % 2 == 0) s_lo = adc_data;
      else issue_word(1'b0, {adc_data, s_lo});
    end
    step();
    rst = 1'b1; adc_valid = 1'b1; adc_data = 16'($urandom);
    step();
    rst = 1'b0; adc_valid = 1'b0;
    exp_seq = '0;
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("overflow_after_rst", 32'(overflow), 32'd0);
    chk("wr_en_after_rst", 32'(fifo_wr_en), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; trigger = 1'b0; fifo_full = 1'b0;
    repeat (3) step();
    chk("rst_fifo_din", fifo_din, 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // trigger without arm does nothing
    repeat (6) begin
      step();
      trigger = 1'b1; adc_valid = 1'b1; adc_data = 16'($urandom); fifo_full = rbit();
    end
    step();
    trigger = 1'b0; adc_valid = 1'b0; fifo_full = 1'b0;
    chk("busy_idle_trigger", 32'(busy), 32'd0);

    run_frame(0, 0, 0, -1, 1'b1);   // consecutive ramp, no backpressure
    run_frame(0, 0, 0, 2, 1'b1);    // third data word hits a full FIFO
    chk("overflow_sticky", 32'(overflow), 32'd1);
    run_frame(1, 1, 0, -1, 1'b1);   // adc_valid every other cycle
    chk("overflow_cleared_by_arm", 32'(overflow), 32'd0);
    run_reset_midframe();
    run_frame(0, 0, 0, -1, 1'b0);   // clean frame after reset
    for (int f = 0; f < 20; f++) run_frame(0, 3, 25, -1, 1'b0);
    run_frame(0, 0, 100, -1, 1'b0); // every slot dropped, frame still ends

    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc2fifo_packer.md
# adc2fifo_packer

Capture-side packer that feeds the sample FIFO drained by the FIFO-to-AXI-Stream DMA stage. Accepts 16-bit ADC samples, packs two per 32-bit word, and writes fixed-length frames into the FIFO after an arm/trigger sequence. Frame length matches the downstream tlast period, so each captured frame becomes exactly one DMA packet. Sticky overflow reporting covers words lost to a full FIFO.

## Interface
- FRAME_WORDS, 16, 32-bit words written per frame (≥2; matches downstream packet length)
- SEQ_W, 16, width of the frame sequence counter
- sysclk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- adc_data  in  16  ADC sample
- adc_valid  in  1  adc_data valid this cycle
- arm  in  1  one-cycle request to start a capture
- trigger  in  1  capture start event, honoured only when armed
- fifo_full  in  1  FIFO full flag (sampled same cycle as write decision)
- fifo_din  out  32  FIFO write data
- fifo_wr_en  out  1  FIFO write strobe
- busy  out  1  high in ARMED or CAPTURE
- frame_done  out  1  one-cycle pulse when last word of a frame is issued
- overflow  out  1  sticky: at least one word dropped since reset/arm

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: arm=1 → ARMED; clears overflow, word counter, half flag.
- ARMED: trigger=1 → CAPTURE; the adc_valid sample in the trigger cycle is the first captured sample. arm ignored.
- CAPTURE: each adc_valid sample: if half flag=0, store in low half-register, set flag; else form word {adc_data, low_half}, clear flag, issue word.
- Issue word: if fifo_full=0, write it; if fifo_full=1, drop it and set overflow. Dropped words still count toward FRAME_WORDS (frame length in time is fixed).
- After FRAME_WORDS issued words: pulse frame_done, increment seq counter (wraps at 2^SEQ_W), → IDLE. Odd trailing sample impossible (frame ends on an issued word).
- arm/trigger in CAPTURE ignored; trigger in IDLE ignored.
- Word counter width $clog2(FRAME_WORDS+1); seq counter not cleared by arm, only by rst.

## Timing
- Reset values: fifo_din=0, fifo_wr_en=0, busy=0, frame_done=0, overflow=0; state IDLE, seq=0, counters 0.
- All outputs registered. fifo_wr_en and fifo_din valid the cycle after the second sample's adc_valid; fifo_full evaluated in the sample cycle.
- frame_done asserts in the same cycle as the final fifo_wr_en (or its dropped slot); busy falls that same cycle.
- adc_valid may be asserted every cycle → one write every 2 cycles max.
- arm and trigger same cycle in IDLE: arm only (trigger needs ARMED).
- rst mid-frame: partial word discarded, no write, → IDLE next cycle.

## Configuration
- ADC2FIFO_HEADER_EN defined: first issued word of each frame is header {16'hA5A5, seq[15:0]} (seq zero-extended if SEQ_W<16), written in the cycle after entering CAPTURE, before any data word; header counts toward FRAME_WORDS (FRAME_WORDS-1 data words). Header subject to the same fifo_full drop rule. Samples with adc_valid during the header cycle are packed normally.
- Undefined: no header; all FRAME_WORDS words are data.

## Test plan
- rst, arm, trigger, 32 consecutive adc_valid samples 0x0000..0x001F, fifo_full=0 → 16 writes, first fifo_din=0x00010000, last 0x001F001E, frame_done with 16th write, overflow=0.
- fifo_full=1 during 3rd data word → 15 writes, word 3 absent, overflow=1, frame_done still after 16th slot.
- trigger before arm, and arm during CAPTURE → no capture / no restart; frame length unchanged.
- rst after 5 samples in CAPTURE → no further writes, busy=0, overflow=0, next arm+trigger starts clean frame.
- With ADC2FIFO_HEADER_EN, two back-to-back frames → first words 0xA5A50000 then 0xA5A50001, 15 data words each.
- adc_valid every other cycle → write every 4 cycles, data order preserved, low sample in bits [15:0].
